// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if - bus bundle for the scoreboarded register file.
//   Write side : we, wa, wd, wbe       (writeback stage)
//   Read side  : ra -> rd, rd_busy     (decode stage, NRD ports)
//   Allocation : alloc_en, alloc_a     (decode stage marks a pending producer)
//   Status     : any_busy              (registered OR of all busy bits)
// master = pipeline side, slave = register file.
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                  we;
    logic [ADDR_W-1:0]     wa;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W/8-1:0]   wbe;
    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rd_busy;
    logic                  alloc_en;
    logic [ADDR_W-1:0]     alloc_a;
    logic                  any_busy;

    modport master (
        output we, wa, wd, wbe, ra, alloc_en, alloc_a,
        input  rd, rd_busy, any_busy
    );

    modport slave (
        input  we, wa, wd, wbe, ra, alloc_en, alloc_a,
        output rd, rd_busy, any_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb - parametrised multi-read-port register file with byte-enable
// writes, optional write-to-read bypass and a per-register busy scoreboard.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears data, busy bits, any_busy)
//   bus   : reg_file_sb_if.slave (write port, NRD read ports, alloc, status)
// Reads are combinational. A full-width write clears the target's busy bit;
// an alloc on the same edge to the same register wins and leaves it busy.
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy, busy_nx;
    logic                         any_q;

    logic [DATA_W-1:0]     bmask;
    logic [DATA_W-1:0]     wr_merged;
    logic                  wr_ok, al_ok, full_wr;
    logic [NRD*DATA_W-1:0] rd_v;
    logic [NRD-1:0]        rdb_v;
    logic [ADDR_W-1:0]     ra_i;
    logic                  hit;

    // Register 0 is hard-wired when ZERO_REG is set: drop writes and allocs.
    assign wr_ok   = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));
    assign al_ok   = bus.alloc_en && !((ZERO_REG != 0) && (bus.alloc_a == '0));
    assign full_wr = &bus.wbe;

    always_comb begin
        bmask = '0;
        for (int k = 0; k < NB; k++)
            bmask[k*8 +: 8] = {8{bus.wbe[k]}};
    end

    // The value reg[wa] holds after the edge; also the bypass value.
    assign wr_merged = (mem[bus.wa] & ~bmask) | (bus.wd & bmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (wr_ok)
            mem[bus.wa] <= wr_merged;
    end

    // Clear first, then set: same-address alloc overrides the clearing write.
    always_comb begin
        busy_nx = busy;
        if (wr_ok && full_wr) busy_nx[bus.wa]    = 1'b0;
        if (al_ok)            busy_nx[bus.alloc_a] = 1'b1;
    end

    // any_busy tracks busy_nx so it is valid right after the causing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            any_q <= 1'b0;
        end else begin
            busy  <= busy_nx;
            any_q <= |busy_nx;
        end
    end

    // Read ports. Outputs are forced to 0 while in reset so an in-flight
    // write cannot leak through the bypass path.
    always_comb begin
        rd_v  = '0;
        rdb_v = '0;
        ra_i  = '0;
        hit   = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra_i = bus.ra[i*ADDR_W +: ADDR_W];
            hit  = (BYPASS != 0) && wr_ok && (bus.wa == ra_i);
            if (rst_n && !((ZERO_REG != 0) && (ra_i == '0))) begin
                rd_v[i*DATA_W +: DATA_W] = hit ? wr_merged : mem[ra_i];
                // A forwarded full write means the producer has just retired.
                rdb_v[i] = (hit && full_wr) ? 1'b0 : busy[ra_i];
            end
        end
    end

    assign bus.rd       = rd_v;
    assign bus.rd_busy  = rdb_v;
    assign bus.any_busy = any_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb - drives a bypassing (ua) and a non-bypassing (ub) register
// file with the same stimulus and checks both against a behavioural model.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, alloc_en;
    logic [4:0]  wa, alloc_a;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic [9:0]  ra;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) ifa ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) ifb ();

    assign ifa.we = we;       assign ifb.we = we;
    assign ifa.wa = wa;       assign ifb.wa = wa;
    assign ifa.wd = wd;       assign ifb.wd = wd;
    assign ifa.wbe = wbe;     assign ifb.wbe = wbe;
    assign ifa.ra = ra;       assign ifb.ra = ra;
    assign ifa.alloc_en = alloc_en; assign ifb.alloc_en = alloc_en;
    assign ifa.alloc_a  = alloc_a;  assign ifb.alloc_a  = alloc_a;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(1))
        ua (.clk(clk), .rst_n(rst_n), .bus(ifa));
    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(0))
        ub (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_any;

    function automatic void m_clear();
        for (int n = 0; n < 32; n++) begin
            m_mem[n]  = 32'h0;
            m_busy[n] = 1'b0;
        end
        m_any = 1'b0;
    endfunction

    always @(negedge rst_n) m_clear();

    always @(posedge clk) begin
        if (!rst_n) m_clear();
        else begin
            if (we && wa != 0) begin
                for (int k = 0; k < 4; k++)
                    if (wbe[k]) m_mem[wa][8*k +: 8] = wd[8*k +: 8];
                if (wbe == 4'hF) m_busy[wa] = 1'b0;
            end
            if (alloc_en && alloc_a != 0) m_busy[alloc_a] = 1'b1;
            m_any = 1'b0;
            for (int n = 0; n < 32; n++) m_any = m_any | m_busy[n];
        end
    end

    function automatic void m_expect(input bit byp, output logic [63:0] erd,
                                     output logic [1:0] eb);
        logic [4:0]  a;
        logic [31:0] v;
        bit          b;
        erd = '0;
        eb  = '0;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                a = ra[i*5 +: 5];
                if (a != 0) begin
                    v = m_mem[a];
                    b = m_busy[a];
                    if (byp && we && wa == a) begin
                        for (int k = 0; k < 4; k++)
                            if (wbe[k]) v[8*k +: 8] = wd[8*k +: 8];
                        if (wbe == 4'hF) b = 1'b0;
                    end
                    erd[i*32 +: 32] = v;
                    eb[i] = b;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Mid-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        logic [63:0] erd;
        logic [1:0]  eb;
        if (run_cmp) begin
            m_expect(1'b1, erd, eb);
            chk("cmp_rd_byp",   ifa.rd, erd);
            chk("cmp_busy_byp", 64'(ifa.rd_busy), 64'(eb));
            chk("cmp_any_byp",  64'(ifa.any_busy), 64'(m_any));
            m_expect(1'b0, erd, eb);
            chk("cmp_rd_nobyp",   ifb.rd, erd);
            chk("cmp_busy_nobyp", 64'(ifb.rd_busy), 64'(eb));
            chk("cmp_any_nobyp",  64'(ifb.any_busy), 64'(m_any));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; wbe = '0;
        alloc_en = 1'b0; alloc_a = '0;
    endtask

    initial begin
        m_clear();
        rst_n = 1'b0;
        idle();
        ra = '0;
        run_cmp = 1'b1;
        tick(); tick();
        chk("reset_rd",  ifa.rd, 64'h0);
        chk("reset_any", 64'(ifa.any_busy), 64'h0);
        rst_n = 1'b1;

        // reg5 written and allocated, then async reset with no clock edge
        we = 1; wa = 5; wd = 32'hDEADBEEF; wbe = 4'hF; alloc_en = 1; alloc_a = 5;
        tick(); idle(); ra = {5'd0, 5'd5}; #1;
        chk("pre_rst_rd",  64'(ifa.rd[31:0]), 64'hDEADBEEF);
        chk("pre_rst_any", 64'(ifa.any_busy), 64'h1);
        rst_n = 1'b0; #1;
        chk("async_rst_rd",   64'(ifa.rd[31:0]), 64'h0);
        chk("async_rst_any",  64'(ifb.any_busy), 64'h0);
        chk("async_rst_busy", 64'(ifa.rd_busy), 64'h0);
        tick(); rst_n = 1'b1; #1;
        chk("post_rst_rd",   64'(ifb.rd[31:0]), 64'h0);
        chk("post_rst_busy", 64'(ifb.rd_busy), 64'h0);

        // full write with same-cycle read of reg3
        we = 1; wa = 3; wd = 32'h12345678; wbe = 4'hF; ra = {5'd0, 5'd3}; #1;
        chk("byp_full",  64'(ifa.rd[31:0]), 64'h12345678);
        chk("nobyp_old", 64'(ifb.rd[31:0]), 64'h0);
        tick(); idle(); #1;
        chk("nobyp_new", 64'(ifb.rd[31:0]), 64'h12345678);

        // byte enables on reg7
        we = 1; wa = 7; wd = 32'hAABBCCDD; wbe = 4'hF;
        tick(); idle();
        we = 1; wa = 7; wd = 32'h11223344; wbe = 4'b0101; ra = {5'd0, 5'd7}; #1;
        chk("byp_merge",   64'(ifa.rd[31:0]), 64'hAA22CC44);
        chk("nobyp_merge", 64'(ifb.rd[31:0]), 64'hAABBCCDD);
        tick(); idle(); #1;
        chk("merge_after", 64'(ifb.rd[31:0]), 64'hAA22CC44);
        chk("model_reg7",  64'(m_mem[7]), 64'hAA22CC44);

        // zero register ignores writes and allocs
        we = 1; wa = 0; wd = 32'hFFFFFFFF; wbe = 4'hF; alloc_en = 1; alloc_a = 0;
        ra = {5'd0, 5'd0}; #1;
        chk("zero_byp", ifa.rd, 64'h0);
        tick(); idle(); #1;
        chk("zero_rd",   ifa.rd, 64'h0);
        chk("zero_busy", 64'(ifa.rd_busy), 64'h0);
        chk("zero_any",  64'(ifa.any_busy), 64'h0);

        // scoreboard on reg9
        alloc_en = 1; alloc_a = 9;
        tick(); idle(); ra = {5'd0, 5'd9}; #1;
        chk("alloc_busy", 64'(ifb.rd_busy[0]), 64'h1);
        chk("alloc_any",  64'(ifa.any_busy), 64'h1);
        we = 1; wa = 9; wd = 32'h0000BEEF; wbe = 4'b0011; #1;
        chk("part_byp_busy", 64'(ifa.rd_busy[0]), 64'h1);
        tick(); idle(); #1;
        chk("part_busy", 64'(ifa.rd_busy[0]), 64'h1);
        chk("part_data", 64'(ifb.rd[31:0]), 64'h0000BEEF);
        we = 1; wa = 9; wd = 32'h1; wbe = 4'hF; #1;
        chk("full_byp_busy",   64'(ifa.rd_busy[0]), 64'h0);
        chk("full_nobyp_busy", 64'(ifb.rd_busy[0]), 64'h1);
        tick(); idle(); #1;
        chk("full_clr_busy", 64'(ifb.rd_busy[0]), 64'h0);
        chk("full_clr_any",  64'(ifb.any_busy), 64'h0);

        // alloc and clearing write to reg4 on the same edge
        we = 1; wa = 4; wd = 32'h55; wbe = 4'hF; alloc_en = 1; alloc_a = 4;
        ra = {5'd4, 5'd4}; #1;
        chk("same_byp_rd",   ifa.rd, {32'h55, 32'h55});
        chk("same_byp_busy", 64'(ifa.rd_busy), 64'h0);
        tick(); idle(); #1;
        chk("same_rd",   ifb.rd, {32'h55, 32'h55});
        chk("same_busy", 64'(ifa.rd_busy), 64'h3);
        chk("same_any",  64'(ifb.any_busy), 64'h1);

        // alloc reg10 and clearing write to reg4 on the same edge
        we = 1; wa = 4; wd = 32'h66; wbe = 4'hF; alloc_en = 1; alloc_a = 10;
        ra = {5'd10, 5'd4};
        tick(); idle(); #1;
        chk("diff_busy", 64'(ifb.rd_busy), 64'h2);
        chk("diff_rd",   64'(ifb.rd[31:0]), 64'h66);

        // mixed traffic over a small address range, checked by the model
        for (int n = 0; n < 60; n++) begin
            we       = 1'($urandom_range(0, 1));
            wa       = 5'($urandom_range(0, 7));
            wd       = $urandom;
            wbe      = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            alloc_en = 1'($urandom_range(0, 1));
            alloc_a  = 5'($urandom_range(0, 7));
            ra       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            tick();
        end
        idle();
        tick(); tick();
        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
